acc_32: RTL and testbench
=========================

# acc_32

Accumulator stage of the Tiny DSP datapath, directly downstream of the 32-bit multiplier. Captures the multiplier's 32-bit product into a P register and, on command, moves, adds, or subtracts P into a 32-bit accumulator (PAC/APAC/SPAC/ZAC-style operations) with optional overflow saturation. A two-state control FSM accepts one op every two cycles through a valid/ready handshake and keeps a sticky overflow flag.

## Interface

Parameters:
- `PSAT`, 32'h7fffffff: positive saturation value.
- `NSAT`, 32'h80000000: negative saturation value.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `prod_in`  input  32  signed product from the multiplier.
- `prod_load`  input  1  load `prod_in` into P at this edge.
- `op`  input  3  operation code, sampled on acceptance.
- `op_valid`  input  1  op request.
- `op_ready`  output  1  block can accept an op this cycle.
- `ovm`  input  1  overflow mode: 1 = saturate, 0 = wrap. Sampled on acceptance.
- `pm`  input  2  product shift mode. Present only with `TDSP_PSHIFT_EN`.
- `p_reg`  output  32  current P register.
- `acc`  output  32  current accumulator.
- `op_done`  output  1  one-cycle pulse when an accepted op retires.
- `ov`  output  1  sticky overflow flag.

## Operation

- **P register:** `p_reg <= prod_in` on any edge where `prod_load` = 1. Otherwise it holds. P loads are independent of the FSM and the handshake.
- **FSM states:**
  - IDLE: `op_ready` = 1.
  - EXEC: `op_ready` = 0.
- **IDLE → EXEC:** on an edge with `op_valid` = 1. The block latches `op`, `ovm`, a snapshot of the operand P, and (if enabled) `pm`.
  - The snapshot is the P value *before* that edge. A simultaneous `prod_load` affects only later ops, which gives pipelined MAC behaviour.
- **EXEC → IDLE:** unconditional at the next edge. At that edge the block writes `acc` and `ov`, and `op_done` is registered high for one cycle.
- **Op codes** (Ps = snapshot P after the optional shift):
  - 000 NOP: acc unchanged.
  - 001 PAC: acc = Ps.
  - 010 APAC: acc = acc + Ps.
  - 011 SPAC: acc = acc − Ps.
  - 100 ZAC: acc = 0.
  - 101 CLRV: ov = 0, acc unchanged.
  - 110 and 111: reserved. Behave as NOP, but still produce `op_done`.
- **Arithmetic:**
  - APAC/SPAC compute a 33-bit signed result by sign-extending both operands.
  - Overflow is detected when bit 32 differs from bit 31.
  - With overflow and `ovm` = 1: acc = `PSAT` if the result is positive, `NSAT` if negative.
  - With overflow and `ovm` = 0: acc = the low 32 bits (wrap).
  - `ov` is set on any overflow regardless of `ovm`. It is cleared only by CLRV or reset.
  - Negating `NSAT` in SPAC is handled by the 33-bit path: 0 − 0x80000000 overflows.
- **Reset** (asynchronous, any state, including mid-EXEC):
  - `acc` = 0, `p_reg` = 0, `ov` = 0, `op_done` = 0, FSM = IDLE, so `op_ready` = 1.
  - An in-flight op is discarded and produces no `op_done`.

## Timing

- Acceptance is the edge k where `op_valid` & `op_ready` = 1.
- `acc` and `ov` update at edge k+1. `op_done` is high during cycle k+1 → k+2.
- Throughput: one op per 2 cycles. `op_ready` is low for exactly the one cycle after acceptance.
- `op_valid` held high continuously gives an op accepted every second edge. The requester must hold `op` stable until accepted.
- A dependent op accepted at k+2 sees the `acc` written at k+1. No hazard exists.
- All outputs are registered. `op_ready` is decoded directly from the state register.

## Configuration

- **`TDSP_PSHIFT_EN` defined:**
  - The `pm` port exists and is latched at acceptance.
  - Ps = P shifted per `pm`: 00 none, 01 left 1, 10 left 4, 11 arithmetic right 6.
  - Left shifts discard the upper bits and do not set `ov`.
- **`TDSP_PSHIFT_EN` undefined:** the `pm` port is absent and Ps = P.

## Test plan

- **Reset:** assert `reset_n` = 0 mid-EXEC → `acc` = 0, `p_reg` = 0, `ov` = 0, `op_ready` = 1, and no `op_done` follows.
- **Load and add:** `prod_load` with `prod_in` = 0x00000010, then PAC, then APAC.
  - After PAC: `acc` = 0x10.
  - After APAC: `acc` = 0x20.
  - Each `op_done` comes one edge after its acceptance.
- **Saturation:** acc = 0x7ffffff0, P = 0x20, APAC.
  - With `ovm` = 1: `acc` = 0x7fffffff, `ov` = 1.
  - With `ovm` = 0: `acc` = 0x80000010, `ov` = 1.
  - A following CLRV gives `ov` = 0 with `acc` unchanged.
- **SPAC edge case:** acc = 0, P = 0x80000000, SPAC, `ovm` = 1 → `acc` = 0x7fffffff, `ov` = 1.
- **Simultaneous load and op:** P = 5; at the same edge, `prod_load` with `prod_in` = 9 and APAC is accepted with acc = 0 → `acc` = 5, `p_reg` = 9. The next APAC gives `acc` = 14.
- **Handshake and shift:** hold `op_valid` high for 4 NOPs → accepted on alternate edges, with `op_ready` toggling. With `TDSP_PSHIFT_EN`, `pm` = 11, P = 0xffffff80, PAC → `acc` = 0xfffffffe.

Source files
------------

// File: rtl/acc_32.sv
// acc_32 - accumulator stage of the Tiny DSP datapath.
//
// Captures the multiplier product into a P register. Accepts one accumulator op
// every two cycles through a valid/ready handshake: move, add or subtract a
// snapshot of P into the accumulator, zero it, or clear the sticky overflow flag.
// Add/subtract can saturate or wrap on overflow.
//
// Optional feature: define TDSP_PSHIFT_EN to add the `pm` port. This shifts the
// P snapshot before it is used: none, left 1, left 4, or arithmetic right 6.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   prod_in    signed 32-bit product from the multiplier
//   prod_load  load prod_in into P at this edge
//   op         operation code, sampled on acceptance
//   op_valid   op request
//   op_ready   block can accept an op this cycle
//   ovm        overflow mode (1 = saturate, 0 = wrap), sampled on acceptance
//   pm         product shift mode (TDSP_PSHIFT_EN only)
//   p_reg      current P register
//   acc        current accumulator
//   op_done    one-cycle pulse when an accepted op retires
//   ov         sticky overflow flag

module acc_32 #(
    parameter logic [31:0] PSAT = 32'h7fffffff,
    parameter logic [31:0] NSAT = 32'h80000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] prod_in,
    input  logic        prod_load,
    input  logic [2:0]  op,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        ovm,
`ifdef TDSP_PSHIFT_EN
    input  logic [1:0]  pm,
`endif
    output logic [31:0] p_reg,
    output logic [31:0] acc,
    output logic        op_done,
    output logic        ov
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpPac  = 3'b001;
    localparam logic [2:0] OpApac = 3'b010;
    localparam logic [2:0] OpSpac = 3'b011;
    localparam logic [2:0] OpZac  = 3'b100;
    localparam logic [2:0] OpClrv = 3'b101;

    state_e      state_q, state_d;
    logic [31:0] p_q;
    logic [31:0] acc_q, acc_d;
    logic        ov_q, ov_d;
    logic        op_done_q;
    logic [2:0]  op_q;
    logic        ovm_q;
    logic [31:0] snap_q;
    logic        accept;
    logic [31:0] ps;
    logic [32:0] sum_w;
    logic [32:0] diff_w;
    logic [32:0] res_w;

`ifdef TDSP_PSHIFT_EN
    logic [1:0] pm_q;
`endif

    assign accept = (state_q == StIdle) && op_valid;

    // Control FSM: IDLE accepts, EXEC always retires on the next edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (op_valid) state_d = StExec;
            StExec: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand after the optional product shift.
`ifdef TDSP_PSHIFT_EN
    always_comb begin
        ps = snap_q;
        unique case (pm_q)
            2'b00: ps = snap_q;
            2'b01: ps = snap_q << 1;
            2'b10: ps = snap_q << 4;
            2'b11: ps = 32'($signed(snap_q) >>> 6);
            default: ps = snap_q;
        endcase
    end
`else
    assign ps = snap_q;
`endif

    // 33-bit sign-extended paths; bit 32 vs bit 31 flags overflow.
    assign sum_w  = {acc_q[31], acc_q} + {ps[31], ps};
    assign diff_w = {acc_q[31], acc_q} - {ps[31], ps};

    always_comb begin
        acc_d = acc_q;
        ov_d  = ov_q;
        res_w = (op_q == OpSpac) ? diff_w : sum_w;
        if (state_q == StExec) begin
            case (op_q)
                OpNop:  acc_d = acc_q;
                OpPac:  acc_d = ps;
                OpApac, OpSpac: begin
                    if (res_w[32] != res_w[31]) begin
                        ov_d  = 1'b1;
                        // bit 32 holds the true sign of the unbounded result
                        acc_d = ovm_q ? (res_w[32] ? NSAT : PSAT) : res_w[31:0];
                    end else begin
                        acc_d = res_w[31:0];
                    end
                end
                OpZac:  acc_d = 32'h0;
                OpClrv: ov_d  = 1'b0;
                default: acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            p_q       <= 32'h0;
            acc_q     <= 32'h0;
            ov_q      <= 1'b0;
            op_done_q <= 1'b0;
            op_q      <= 3'b000;
            ovm_q     <= 1'b0;
            snap_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ov_q      <= ov_d;
            op_done_q <= (state_q == StExec);
            if (prod_load) p_q <= prod_in;
            // Snapshot is the pre-edge P, so a same-edge load only affects later ops.
            if (accept) begin
                op_q   <= op;
                ovm_q  <= ovm;
                snap_q <= p_q;
            end
        end
    end

`ifdef TDSP_PSHIFT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pm_q <= 2'b00;
        end else if (accept) begin
            pm_q <= pm;
        end
    end
`endif

    assign op_ready = (state_q == StIdle);
    assign p_reg    = p_q;
    assign acc      = acc_q;
    assign op_done  = op_done_q;
    assign ov       = ov_q;

endmodule

// File: tb/tb_acc_32.sv
module tb_acc_32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] prod_in;
    logic        prod_load;
    logic [2:0]  op;
    logic        op_valid;
    logic        op_ready;
    logic        ovm;
    logic [1:0]  pm;
    logic [31:0] p_reg;
    logic [31:0] acc;
    logic        op_done;
    logic        ov;

    always #5 clk = ~clk;

    acc_32 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .prod_in   (prod_in),
        .prod_load (prod_load),
        .op        (op),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .ovm       (ovm),
`ifdef TDSP_PSHIFT_EN
        .pm        (pm),
`endif
        .p_reg     (p_reg),
        .acc       (acc),
        .op_done   (op_done),
        .ov        (ov)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_acc, m_p, q_ps;
    logic        m_ov, m_done, m_busy, q_ovm;
    logic [2:0]  q_op;

    function automatic logic [31:0] shifted(input logic [31:0] p, input logic [1:0] m);
`ifdef TDSP_PSHIFT_EN
        case (m)
            2'd1: return 32'(p * 2);
            2'd2: return 32'(p * 16);
            2'd3: return 32'($signed(p) >>> 6);
            default: return p;
        endcase
`else
        if (m == 2'd0) return p;
        return p;
`endif
    endfunction

    // Returns {ov, acc} after applying one op using plain integer arithmetic.
    function automatic logic [32:0] model_apply(input logic [2:0] o, input logic sat,
                                                input logic [31:0] ps, input logic [31:0] a,
                                                input logic v);
        longint r;
        longint hi = 64'sd2147483647;
        longint lo = -64'sd2147483648;
        case (o)
            3'd1: return {v, ps};
            3'd2: r = longint'($signed(a)) + longint'($signed(ps));
            3'd3: r = longint'($signed(a)) - longint'($signed(ps));
            3'd4: return {v, 32'h0};
            3'd5: return {1'b0, a};
            default: return {v, a};
        endcase
        if (r > hi) return {1'b1, sat ? 32'h7fffffff : r[31:0]};
        if (r < lo) return {1'b1, sat ? 32'h80000000 : r[31:0]};
        return {v, r[31:0]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc  <= 32'h0;
            m_ov   <= 1'b0;
            m_p    <= 32'h0;
            m_done <= 1'b0;
            m_busy <= 1'b0;
            q_op   <= 3'd0;
            q_ovm  <= 1'b0;
            q_ps   <= 32'h0;
        end else begin
            m_done <= m_busy;
            if (prod_load) m_p <= prod_in;
            if (!m_busy && op_valid) begin
                m_busy <= 1'b1;
                q_op   <= op;
                q_ovm  <= ovm;
                q_ps   <= shifted(m_p, pm);
            end else if (m_busy) begin
                m_busy <= 1'b0;
                {m_ov, m_acc} <= model_apply(q_op, q_ovm, q_ps, m_acc, m_ov);
            end
        end
    end

    // ---------------- compare process ----------------
    int          total = 0;
    int          bad = 0;
    logic        chk_en = 1'b0;
    int          lit_seq = 0;
    int          lit_seen = 0;
    string       lit_name;
    logic [31:0] lit_acc, lit_p;
    logic        lit_ov, lit_ready, lit_done;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("acc", acc, m_acc);
            chk("ov", 32'(ov), 32'(m_ov));
            chk("p_reg", p_reg, m_p);
            chk("op_ready", 32'(op_ready), 32'(!m_busy));
            chk("op_done", 32'(op_done), 32'(m_done));
        end
        if (lit_seq != lit_seen) begin
            chk({lit_name, ".acc"}, acc, lit_acc);
            chk({lit_name, ".ov"}, 32'(ov), 32'(lit_ov));
            chk({lit_name, ".p_reg"}, p_reg, lit_p);
            chk({lit_name, ".op_ready"}, 32'(op_ready), 32'(lit_ready));
            chk({lit_name, ".op_done"}, 32'(op_done), 32'(lit_done));
            chk({lit_name, ".model_acc"}, m_acc, lit_acc);
            chk({lit_name, ".model_ov"}, 32'(m_ov), 32'(lit_ov));
            lit_seen = lit_seq;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep, input logic er, input logic ed);
        lit_name  = n;
        lit_acc   = ea;
        lit_ov    = ev;
        lit_p     = ep;
        lit_ready = er;
        lit_done  = ed;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic load_p(input logic [31:0] v);
        prod_load = 1'b1;
        prod_in   = v;
        tick();
        prod_load = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic sat);
        op       = o;
        ovm      = sat;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
    endtask

    localparam logic [2:0] NOP = 3'd0, PAC = 3'd1, APAC = 3'd2, SPAC = 3'd3,
                           ZAC = 3'd4, CLRV = 3'd5;

    initial begin
        reset_n   = 1'b0;
        prod_in   = 32'h0;
        prod_load = 1'b0;
        op        = NOP;
        op_valid  = 1'b0;
        ovm       = 1'b0;
        pm        = 2'b00;
        tick();
        tick();
        chk_en = 1'b1;
        lit("reset", 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        reset_n = 1'b1;
        tick();

        // load and add
        load_p(32'h10);
        run_op(PAC, 1'b0);
        lit("pac", 32'h10, 1'b0, 32'h10, 1'b1, 1'b1);
        run_op(APAC, 1'b0);
        lit("apac", 32'h20, 1'b0, 32'h10, 1'b1, 1'b1);

        // saturation and wrap
        load_p(32'h7ffffff0);
        run_op(PAC, 1'b0);
        load_p(32'h20);
        run_op(APAC, 1'b1);
        lit("sat_pos", 32'h7fffffff, 1'b1, 32'h20, 1'b1, 1'b1);
        run_op(CLRV, 1'b0);
        lit("clrv", 32'h7fffffff, 1'b0, 32'h20, 1'b1, 1'b1);
        load_p(32'h7ffffff0);
        run_op(PAC, 1'b0);
        load_p(32'h20);
        run_op(APAC, 1'b0);
        lit("wrap", 32'h80000010, 1'b1, 32'h20, 1'b1, 1'b1);
        run_op(CLRV, 1'b0);
        lit("clrv2", 32'h80000010, 1'b0, 32'h20, 1'b1, 1'b1);

        // SPAC edge cases
        run_op(ZAC, 1'b0);
        load_p(32'h80000000);
        run_op(SPAC, 1'b1);
        lit("spac_sat", 32'h7fffffff, 1'b1, 32'h80000000, 1'b1, 1'b1);
        run_op(CLRV, 1'b0);
        run_op(ZAC, 1'b0);
        run_op(SPAC, 1'b0);
        lit("spac_wrap", 32'h80000000, 1'b1, 32'h80000000, 1'b1, 1'b1);
        run_op(CLRV, 1'b0);
        load_p(32'h1);
        run_op(SPAC, 1'b1);
        lit("neg_sat", 32'h80000000, 1'b1, 32'h1, 1'b1, 1'b1);
        run_op(CLRV, 1'b0);

        // simultaneous load and accept
        run_op(ZAC, 1'b0);
        load_p(32'd5);
        op        = APAC;
        ovm       = 1'b0;
        op_valid  = 1'b1;
        prod_load = 1'b1;
        prod_in   = 32'd9;
        tick();
        op_valid  = 1'b0;
        prod_load = 1'b0;
        tick();
        lit("simul", 32'd5, 1'b0, 32'd9, 1'b1, 1'b1);
        run_op(APAC, 1'b0);
        lit("simul2", 32'd14, 1'b0, 32'd9, 1'b1, 1'b1);

        // reserved code behaves as NOP but still retires
        run_op(3'b110, 1'b0);
        lit("rsvd", 32'd14, 1'b0, 32'd9, 1'b1, 1'b1);

        // handshake: valid held for four NOPs
        op       = NOP;
        op_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            lit($sformatf("hs%0d", i), 32'd14, 1'b0, 32'd9, (i % 2) == 0, (i % 2) == 0);
        end
        op_valid = 1'b0;
        tick();

`ifdef TDSP_PSHIFT_EN
        pm = 2'b11;
        load_p(32'hffffff80);
        run_op(PAC, 1'b0);
        lit("shr6", 32'hfffffffe, 1'b0, 32'hffffff80, 1'b1, 1'b1);
        pm = 2'b01;
        load_p(32'h40000001);
        run_op(PAC, 1'b0);
        lit("shl1", 32'h80000002, 1'b0, 32'h40000001, 1'b1, 1'b1);
        pm = 2'b10;
        load_p(32'h12345678);
        run_op(PAC, 1'b0);
        lit("shl4", 32'h23456780, 1'b0, 32'h12345678, 1'b1, 1'b1);
        pm = 2'b00;
`endif

        // reset in the middle of EXEC
        run_op(ZAC, 1'b0);
        load_p(32'h80000000);
        run_op(SPAC, 1'b0);
        op       = APAC;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        lit("rst_mid", 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        lit("post_rst", 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
